// File: rtl/fetch_decode_stage.sv
// fetch_decode_stage: PC owner, req/ack instruction fetch and RV32I field decode.
// Fields are registered on each fetch handshake and presented with valid_out.
// Stall freezes the stage. Redirect reloads the PC, flushes the stage and wins over everything else.
module fetch_decode_stage #(
  parameter int unsigned WIDTH    = 8,
  parameter int unsigned PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  output logic                imem_req,
  output logic [PC_WIDTH-1:0] imem_addr,
  input  logic                imem_ack,
  input  logic [31:0]         imem_rdata,
  input  logic                stall,
  input  logic                redirect,
  input  logic [PC_WIDTH-1:0] redirect_pc,
  output logic [4:0]          r_reg1,
  output logic [4:0]          r_reg2,
  output logic [4:0]          wr_reg,
  output logic [2:0]          func3,
  output logic [6:0]          func7,
  output logic [6:0]          opcode,
  output logic [WIDTH-1:0]    immediate_data,
  output logic [PC_WIDTH-1:0] pc_out,
  output logic                valid_out
);

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    HALT  = 2'd2
  } state_t;

  state_t              state;
  state_t              state_next;
  logic [PC_WIDTH-1:0] pc;
  logic                handshake;
  logic [31:0]         imm32;

  // Fetch request is withdrawn immediately on stall or redirect.
  assign imem_req  = (state == FETCH) & ~stall & ~redirect;
  assign imem_addr = pc;
  assign handshake = imem_req & imem_ack;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: IDLE is a one-cycle start-up state; ECALL parks the stage until a redirect.
  always_comb begin
    state_next = state;
    if (redirect) begin
      state_next = FETCH;
    end else begin
      unique case (state)
        IDLE:    state_next = FETCH;
        FETCH:   if (handshake && (imem_rdata == ECALL_WORD)) state_next = HALT;
        HALT:    state_next = HALT;
        default: state_next = IDLE;
      endcase
    end
  end

  // Sign-extended 32-bit immediate selected by the opcode format.
  always_comb begin
    imm32 = 32'h0;
    unique case (imem_rdata[6:0])
      OP_IMM, OP_LOAD, OP_JALR:
        imm32 = {{20{imem_rdata[31]}}, imem_rdata[31:20]};
      OP_STORE:
        imm32 = {{20{imem_rdata[31]}}, imem_rdata[31:25], imem_rdata[11:7]};
      OP_BRANCH:
        imm32 = {{19{imem_rdata[31]}}, imem_rdata[31], imem_rdata[7],
                 imem_rdata[30:25], imem_rdata[11:8], 1'b0};
      OP_LUI, OP_AUIPC:
        imm32 = {imem_rdata[31:12], 12'h000};
      OP_JAL:
        imm32 = {{11{imem_rdata[31]}}, imem_rdata[31], imem_rdata[19:12],
                 imem_rdata[20], imem_rdata[30:21], 1'b0};
      default:
        imm32 = 32'h0;
    endcase
  end

  // PC, decoded fields and valid flag; redirect beats stall, stall freezes the stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc             <= '0;
      pc_out         <= '0;
      valid_out      <= 1'b0;
      r_reg1         <= '0;
      r_reg2         <= '0;
      wr_reg         <= '0;
      func3          <= '0;
      func7          <= '0;
      opcode         <= '0;
      immediate_data <= '0;
    end else if (redirect) begin
      pc        <= redirect_pc;
      valid_out <= 1'b0;
    end else if (!stall) begin
      if (handshake) begin
        r_reg1         <= imem_rdata[19:15];
        r_reg2         <= imem_rdata[24:20];
        wr_reg         <= imem_rdata[11:7];
        func3          <= imem_rdata[14:12];
        func7          <= imem_rdata[31:25];
        opcode         <= imem_rdata[6:0];
        immediate_data <= WIDTH'(imm32);
        pc_out         <= pc;
        pc             <= pc + PC_WIDTH'(4);
        valid_out      <= 1'b1;
      end else begin
        // Presented instruction is consumed; nothing new arrived to replace it.
        valid_out <= 1'b0;
      end
    end
  end

endmodule
